ins_encode: RTL and testbench
=============================

INS_ENCODE -- requirements
Module: ins_encode

Interface
REQ-001 SHALL have parameter: DEPTH, 4, output FIFO entries (power of two, at least 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  request carries an instruction to encode.
REQ-005 SHALL have port: in_ready  output  1  encoder accepts a request this cycle.
REQ-006 SHALL have port: data_path  input  3  class code (1 arith, 2 logical, 3 memory, 4 compare, 5 jump, 6 branch).
REQ-007 SHALL have port: type  input  4  operation code within class.
REQ-008 SHALL have port: rs, rt, rd  input  5 each  register fields.
REQ-009 SHALL have port: imm  input  16  immediate or branch offset.
REQ-010 SHALL have port: target  input  26  jump target.
REQ-011 SHALL have port: ins  output  32  encoded instruction at FIFO head.
REQ-012 SHALL have port: ins_valid  output  1  ins holds a valid word.
REQ-013 SHALL have port: ins_ready  input  1  consumer takes the head word.
REQ-014 SHALL have port: err_pulse  output  1  illegal request seen.
REQ-015 SHALL have port: err_cnt  output  8  illegal-request count.

Function
REQ-016 SHALL accept a request on a rising edge where in_valid and in_ready are both high; in_ready SHALL equal not-full.
REQ-017 SHALL encode as follows. dp1/type0: opcode 0, funct 32. dp1/type1: opcode 0, funct 34. dp2 type2/3/4/5: opcode 13/12/15/10. dp3 type0/1: opcode 40/41. dp4/type6: opcode 32. dp5 any type: opcode 56. dp6 type7/8/9: opcode 20/21/23.
REQ-018 SHALL lay out the word as follows. R-type (dp1): [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] zero, [5:0] funct. I-type (dp2,3,4,6): opcode, rs, rt, [15:0] imm. J-type (dp5): opcode, [25:0] target.
REQ-019 SHALL treat any combination not listed in REQ-017 as illegal. Illegal requests are accepted but not pushed, and err_pulse is high for exactly the next cycle.
REQ-020 SHALL register each encoded legal word into the FIFO tail on the accepting edge, giving 1-cycle latency: ins_valid is high in the cycle after acceptance into an empty FIFO. There is no combinational bypass.
REQ-021 SHALL drive ins from the FIFO head and set ins_valid equal to not-empty; the head SHALL pop on an edge where ins_valid and ins_ready are both high.
REQ-022 SHALL leave the count unchanged when a push and a pop occur on the same edge, and SHALL preserve order.
REQ-023 SHALL hold in_ready low when full, so no push occurs even if a pop occurs on the same edge; in_ready rises the cycle after the pop.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL hold ins stable while ins_valid is high and ins_ready is low.
REQ-026 SHALL increment err_cnt once per illegal request and saturate at 255.

Reset
REQ-027 SHALL, while rst_n is low, force pointers and count to 0, ins_valid to 0, err_pulse to 0, err_cnt to 0 and ins to 0; in_ready SHALL be 1.
REQ-028 SHALL discard all queued entries on reset mid-operation. No partial word SHALL appear after rst_n rises.

Configuration
REQ-029 SHALL, with ENC_ERR_CNT_EN defined, implement err_cnt per REQ-026.
REQ-030 SHALL, without ENC_ERR_CNT_EN, tie err_cnt to 0 with no counter flops. err_pulse is unaffected.

Structure
REQ-031 SHALL take opcode, funct, data_path and type constants from shared package rb_isa_pkg, which the decoder also uses.
REQ-032 SHALL place storage in sub-module ins_fifo (parameter DEPTH, 32-bit data, push/pop/full/empty).

Verification
REQ-033 SHALL check: dp1, type0, rs=1, rt=2, rd=3 -> ins=32'h00221820 one cycle later.
REQ-034 SHALL check: dp6, type7, rs=4, rt=5, imm=16'h0010 -> ins=32'h50850010.
REQ-035 SHALL check: dp5, target=26'h0000100 -> ins=32'hE0000100.
REQ-036 SHALL check: 5 back-to-back requests with ins_ready=0 -> 4 accepted, in_ready low after the 4th; one pop -> in_ready high next cycle; words emerge in order.
REQ-037 SHALL check: dp=7 request -> nothing queued, err_pulse high for 1 cycle, err_cnt=1 (0 without ENC_ERR_CNT_EN); 300 illegal requests -> err_cnt=255.
REQ-038 SHALL check: 2 entries queued, rst_n pulsed low mid-cycle -> ins_valid 0 immediately, in_ready 1, FIFO empty after release.

Source files
------------

// File: rtl/rb_isa_pkg.sv
// Shared ISA constants and the class/type -> opcode/funct lookup,
// used by both the encoder and the decoder.
package rb_isa_pkg;

    localparam logic [2:0] DP_ARITH  = 3'd1;
    localparam logic [2:0] DP_LOGIC  = 3'd2;
    localparam logic [2:0] DP_MEM    = 3'd3;
    localparam logic [2:0] DP_CMP    = 3'd4;
    localparam logic [2:0] DP_JUMP   = 3'd5;
    localparam logic [2:0] DP_BRANCH = 3'd6;

    localparam logic [3:0] TY_ADD  = 4'd0;
    localparam logic [3:0] TY_SUB  = 4'd1;
    localparam logic [3:0] TY_ORI  = 4'd2;
    localparam logic [3:0] TY_ANDI = 4'd3;
    localparam logic [3:0] TY_LUI  = 4'd4;
    localparam logic [3:0] TY_SLTI = 4'd5;
    localparam logic [3:0] TY_SB   = 4'd0;
    localparam logic [3:0] TY_SH   = 4'd1;
    localparam logic [3:0] TY_CMP  = 4'd6;
    localparam logic [3:0] TY_BEQ  = 4'd7;
    localparam logic [3:0] TY_BNE  = 4'd8;
    localparam logic [3:0] TY_BGTZ = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_CMP   = 6'd32;
    localparam logic [5:0] OP_J     = 6'd56;
    localparam logic [5:0] OP_BEQ   = 6'd20;
    localparam logic [5:0] OP_BNE   = 6'd21;
    localparam logic [5:0] OP_BGTZ  = 6'd23;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;

    typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

    typedef struct packed {
        logic       legal;
        fmt_e       fmt;
        logic [5:0] opcode;
        logic [5:0] funct;
    } enc_s;

    function automatic enc_s isa_lookup(input logic [2:0] dp, input logic [3:0] ty);
        enc_s e;
        e.legal  = 1'b0;
        e.fmt    = FMT_I;
        e.opcode = OP_RTYPE;
        e.funct  = 6'd0;
        case (dp)
            DP_ARITH: begin
                e.fmt = FMT_R;
                case (ty)
                    TY_ADD:  begin e.legal = 1'b1; e.funct = FN_ADD; end
                    TY_SUB:  begin e.legal = 1'b1; e.funct = FN_SUB; end
                    default: e.legal = 1'b0;
                endcase
            end
            DP_LOGIC: begin
                e.legal = 1'b1;
                case (ty)
                    TY_ORI:  e.opcode = OP_ORI;
                    TY_ANDI: e.opcode = OP_ANDI;
                    TY_LUI:  e.opcode = OP_LUI;
                    TY_SLTI: e.opcode = OP_SLTI;
                    default: e.legal  = 1'b0;
                endcase
            end
            DP_MEM: begin
                e.legal = 1'b1;
                case (ty)
                    TY_SB:   e.opcode = OP_SB;
                    TY_SH:   e.opcode = OP_SH;
                    default: e.legal  = 1'b0;
                endcase
            end
            DP_CMP: begin
                e.legal  = (ty == TY_CMP);
                e.opcode = OP_CMP;
            end
            // Jumps ignore the type field entirely.
            DP_JUMP: begin
                e.legal  = 1'b1;
                e.fmt    = FMT_J;
                e.opcode = OP_J;
            end
            DP_BRANCH: begin
                e.legal = 1'b1;
                case (ty)
                    TY_BEQ:  e.opcode = OP_BEQ;
                    TY_BNE:  e.opcode = OP_BNE;
                    TY_BGTZ: e.opcode = OP_BGTZ;
                    default: e.legal  = 1'b0;
                endcase
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/ins_fifo.sv
// Small register-based FIFO holding encoded instruction words.
// Read data is forced to zero while empty so the head never shows stale data.
module ins_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = empty_o ? 32'd0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ins_encode.sv
// Instruction encoder: maps class/type/fields to a 32-bit word queued in ins_fifo.
// Define ENC_ERR_CNT_EN to build the saturating illegal-request counter.
module ins_encode #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  data_path,
    input  logic [3:0]  op_type,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic        err_pulse,
    output logic [7:0]  err_cnt
);

    import rb_isa_pkg::*;

    enc_s        enc;
    logic [31:0] word;
    logic        accept, push, pop;
    logic        fifo_full, fifo_empty;
    logic        err_pulse_q, err_pulse_d;

    always_comb begin
        enc = isa_lookup(data_path, op_type);
        case (enc.fmt)
            FMT_R:   word = {enc.opcode, rs, rt, rd, 5'd0, enc.funct};
            FMT_I:   word = {enc.opcode, rs, rt, imm};
            default: word = {enc.opcode, target};
        endcase
    end

    assign in_ready    = ~fifo_full;
    assign ins_valid   = ~fifo_empty;
    assign accept      = in_valid & in_ready;
    assign push        = accept & enc.legal;
    assign pop         = ins_valid & ins_ready;
    // Illegal requests are still handshaken so the producer never stalls on them.
    assign err_pulse_d = accept & ~enc.legal;
    assign err_pulse   = err_pulse_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_q <= 1'b0;
        end else begin
            err_pulse_q <= err_pulse_d;
        end
    end

`ifdef ENC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_pulse_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

    ins_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (word),
        .rdata_o (ins),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_ins_encode.sv
// Self-checking bench for ins_encode: directed vectors plus randomized traffic
// against a table-driven queue model.
module tb_ins_encode;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  dp = '0;
    logic [3:0]  ty = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0;
    logic [15:0] imm = '0;
    logic [25:0] tgt = '0;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        err_pulse;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mq[$];
    int          m_cnt = 0;
    bit          m_pulse = 1'b0;

    always #5 clk = ~clk;

    ins_encode #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_path (dp),
        .op_type   (ty),
        .rs        (rs),
        .rt        (rt),
        .rd        (rd),
        .imm       (imm),
        .target    (tgt),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    // Encoding table straight from the requirements: {class, type (-1 = any), opcode, funct}.
    function automatic bit ref_encode(input int d, input int t, input int r_s, input int r_t,
                                      input int r_d, input int im, input int tg,
                                      output logic [31:0] w);
        int tbl [13][4] = '{
            '{1, 0, 0, 32}, '{1, 1, 0, 34},
            '{2, 2, 13, 0}, '{2, 3, 12, 0}, '{2, 4, 15, 0}, '{2, 5, 10, 0},
            '{3, 0, 40, 0}, '{3, 1, 41, 0},
            '{4, 6, 32, 0},
            '{5, -1, 56, 0},
            '{6, 7, 20, 0}, '{6, 8, 21, 0}, '{6, 9, 23, 0}};
        longint acc;
        w = 32'd0;
        for (int k = 0; k < 13; k++) begin
            if (tbl[k][0] == d && (tbl[k][1] == t || tbl[k][1] < 0)) begin
                acc = longint'(tbl[k][2]) * 64'd67108864;
                if (d == 1)
                    acc += r_s * 2097152 + r_t * 65536 + r_d * 2048 + tbl[k][3];
                else if (d == 5)
                    acc += tg;
                else
                    acc += r_s * 2097152 + r_t * 65536 + im;
                w = 32'(acc);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic int exp_cnt();
`ifdef ENC_ERR_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    // Clock one edge, updating the model from the inputs applied before it.
    task automatic advance();
        bit acc, pop, legal;
        logic [31:0] w;
        acc   = in_valid && (mq.size() < DEPTH);
        pop   = ins_ready && (mq.size() > 0);
        legal = ref_encode(int'(dp), int'(ty), int'(rs), int'(rt), int'(rd), int'(imm), int'(tgt), w);
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc && legal) mq.push_back(w);
        m_pulse = acc && !legal;
        if (acc && !legal && m_cnt < 255) m_cnt++;
    endtask

    task automatic set_req(input logic [2:0] d, input logic [3:0] t, input logic [4:0] a,
                           input logic [4:0] b, input logic [4:0] c, input logic [15:0] i,
                           input logic [25:0] g);
        in_valid = 1'b1;
        dp = d; ty = t; rs = a; rt = b; rd = c; imm = i; tgt = g;
    endtask

    task automatic clear_model();
        mq.delete();
        m_cnt = 0;
        m_pulse = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        ins_ready = 1'b0;
        clear_model();
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL reset_ins_valid got=%b want=0", ins_valid); end
        n_cmp++; if (ins !== 32'd0) begin n_err++; $display("FAIL reset_ins got=%h want=0", ins); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL reset_err_pulse got=%b want=0", err_pulse); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        rst_n = 1'b1;
        advance();
        $display("reset: released, queue empty");
    endtask

    task automatic test_directed();
        logic [2:0]  vd [3]  = '{3'd1, 3'd6, 3'd5};
        logic [3:0]  vt [3]  = '{4'd0, 4'd7, 4'd0};
        logic [4:0]  va [3]  = '{5'd1, 5'd4, 5'd0};
        logic [4:0]  vb [3]  = '{5'd2, 5'd5, 5'd0};
        logic [4:0]  vc [3]  = '{5'd3, 5'd0, 5'd0};
        logic [15:0] vi [3]  = '{16'h0, 16'h0010, 16'h0};
        logic [25:0] vg [3]  = '{26'h0, 26'h0, 26'h0000100};
        logic [31:0] vw [3]  = '{32'h00221820, 32'h50850010, 32'hE0000100};
        for (int k = 0; k < 3; k++) begin
            ins_ready = 1'b0;
            set_req(vd[k], vt[k], va[k], vb[k], vc[k], vi[k], vg[k]);
            advance();
            in_valid = 1'b0;
            n_cmp++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL directed%0d_valid got=%b want=1", k, ins_valid); end
            n_cmp++; if (ins !== vw[k]) begin n_err++; $display("FAIL directed%0d_ins got=%h want=%h", k, ins, vw[k]); end
            ins_ready = 1'b1;
            advance();
            ins_ready = 1'b0;
            n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL directed%0d_popped got=%b want=0", k, ins_valid); end
            $display("directed %0d: dp=%0d ty=%0d -> ins=%h", k, vd[k], vt[k], vw[k]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        ins_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(3'd5, 4'($urandom_range(0, 15)), 5'd0, 5'd0, 5'd0, 16'd0, 26'h100 + 26'(k));
            n_cmp++; if (in_ready !== (k < 4)) begin n_err++; $display("FAIL b2b_in_ready%0d got=%b want=%b", k, in_ready, k < 4); end
            advance();
        end
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full got=%b want=0", in_ready); end
        n_cmp++; if (ins !== 32'hE0000100) begin n_err++; $display("FAIL b2b_head_hold got=%h want=e0000100", ins); end
        ins_ready = 1'b1;
        advance();
        ins_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_after_pop got=%b want=1", in_ready); end
        ins_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            w = 32'hE0000100 + 32'(k);
            n_cmp++; if (ins !== w) begin n_err++; $display("FAIL b2b_order%0d got=%h want=%h", k, ins, w); end
            advance();
        end
        ins_ready = 1'b0;
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained got=%b want=0", ins_valid); end
        $display("back_to_back: 4 of 5 accepted, drained in order");
    endtask

    task automatic test_illegal();
        ins_ready = 1'b1;
        set_req(3'd7, 4'd0, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0);
        advance();
        in_valid = 1'b0;
        n_cmp++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL illegal_pulse got=%b want=1", err_pulse); end
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL illegal_not_queued got=%b want=0", ins_valid); end
        n_cmp++; if (int'(err_cnt) !== exp_cnt()) begin n_err++; $display("FAIL illegal_cnt1 got=%0d want=%0d", err_cnt, exp_cnt()); end
        advance();
        n_cmp++; if (err_pulse !== 1'b0) begin n_err++; $display("FAIL illegal_pulse_width got=%b want=0", err_pulse); end
        for (int k = 0; k < 300; k++) begin
            set_req(3'd0, 4'($urandom_range(0, 15)), 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
            if (k % 2 == 1) dp = 3'd7;
            advance();
        end
        in_valid = 1'b0;
        advance();
        n_cmp++; if (int'(err_cnt) !== exp_cnt()) begin n_err++; $display("FAIL illegal_saturate got=%0d want=%0d", err_cnt, exp_cnt()); end
`ifdef ENC_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 8'd255) begin n_err++; $display("FAIL illegal_sat255 got=%0d want=255", err_cnt); end
`else
        n_cmp++; if (err_cnt !== 8'd0) begin n_err++; $display("FAIL illegal_tied0 got=%0d want=0", err_cnt); end
`endif
        $display("illegal: 301 illegal requests, err_cnt=%0d", err_cnt);
    endtask

    task automatic test_reset_mid();
        ins_ready = 1'b0;
        set_req(3'd2, 4'd3, 5'd7, 5'd9, 5'd0, 16'hBEEF, 26'd0);
        advance();
        set_req(3'd3, 4'd1, 5'd2, 5'd3, 5'd0, 16'h0042, 26'd0);
        advance();
        in_valid = 1'b0;
        n_cmp++; if (ins_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid got=%b want=1", ins_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b want=0", ins_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (ins !== 32'd0) begin n_err++; $display("FAIL midrst_ins got=%h want=0", ins); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        advance();
        n_cmp++; if (ins_valid !== 1'b0) begin n_err++; $display("FAIL midrst_after_valid got=%b want=0", ins_valid); end
        n_cmp++; if (ins !== 32'd0) begin n_err++; $display("FAIL midrst_after_ins got=%h want=0", ins); end
        $display("reset_mid: queue discarded");
    endtask

    task automatic test_random();
        logic [31:0] w;
        int errs_before;
        errs_before = n_err;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            dp        = 3'($urandom_range(0, 7));
            ty        = 4'($urandom_range(0, 10));
            rs        = 5'($urandom);
            rt        = 5'($urandom);
            rd        = 5'($urandom);
            imm       = 16'($urandom);
            tgt       = 26'($urandom);
            ins_ready = ($urandom_range(0, 2) == 0);
            advance();
            w = (mq.size() > 0) ? mq[0] : 32'd0;
            n_cmp++; if (in_ready !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd%0d_in_ready got=%b want=%b", c, in_ready, mq.size() < DEPTH); end
            n_cmp++; if (ins_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd%0d_valid got=%b want=%b", c, ins_valid, mq.size() > 0); end
            n_cmp++; if (ins !== w) begin n_err++; $display("FAIL rnd%0d_ins got=%h want=%h", c, ins, w); end
            n_cmp++; if (err_pulse !== m_pulse) begin n_err++; $display("FAIL rnd%0d_pulse got=%b want=%b", c, err_pulse, m_pulse); end
            n_cmp++; if (int'(err_cnt) !== exp_cnt()) begin n_err++; $display("FAIL rnd%0d_cnt got=%0d want=%0d", c, err_cnt, exp_cnt()); end
        end
        in_valid = 1'b0;
        $display("random: 600 cycles, %0d new mismatches", n_err - errs_before);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
